// File: rtl/alu_serial_seq_if.sv
// Operand/result bundle for the bit-serial ALU sequencer; the ovf flag is carried only
// when ALU_SERIAL_OVF_EN is defined.
interface alu_serial_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf;

    modport master (output start, a, b, op, input busy, done, result, cout, zero, ovf);
    modport slave  (input start, a, b, op, output busy, done, result, cout, zero, ovf);
`else
    modport master (output start, a, b, op, input busy, done, result, cout, zero);
    modport slave  (input start, a, b, op, output busy, done, result, cout, zero);
`endif
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial WIDTH-bit ALU (NOR/XOR/ADD/SUB), one bit per clock LSB first; ALU_SERIAL_OVF_EN adds ovf.
// Latency: WIDTH+1 cycles start-to-done; start held into DONE gives one op per WIDTH+1 cycles.
// Backpressure: none; start is ignored while busy and results hold until the next accept.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    alu_serial_seq_if.slave bus
);
    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
    localparam logic [1:0]    OP_NOR = 2'b00;
    localparam logic [1:0]    OP_XOR = 2'b01;
    localparam logic [1:0]    OP_SUB = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [1:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
`ifdef ALU_SERIAL_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             arith;
    logic             b_bit;
    logic             s_bit;
    logic             carry_nx;
    logic [WIDTH-1:0] final_res;

    // 1-bit ALU slice; SUB reuses the adder with b inverted and carry preset to 1
    always_comb begin
        arith    = op_q[1];
        b_bit    = b_sh_q[0] ^ (op_q == OP_SUB);
        carry_nx = (a_sh_q[0] & b_bit) | (a_sh_q[0] & carry_q) | (b_bit & carry_q);
        case (op_q)
            OP_NOR:  s_bit = ~(a_sh_q[0] | b_sh_q[0]);
            OP_XOR:  s_bit = a_sh_q[0] ^ b_sh_q[0];
            default: s_bit = a_sh_q[0] ^ b_bit ^ carry_q;
        endcase
        final_res = {s_bit, res_sh_q};
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    op_d    = bus.op;
                    carry_d = (bus.op == OP_SUB);
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_sh_q >> 1;
                res_sh_d[WIDTH-2] = s_bit;
                carry_d  = arith ? carry_nx : 1'b0;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d  = DONE;
                    result_d = final_res;
                    cout_d   = arith ? carry_nx : 1'b0;
                    zero_d   = (final_res == '0);
`ifdef ALU_SERIAL_OVF_EN
                    // carry_q is the carry into the MSB on this last bit
                    ovf_d    = arith ? (carry_q ^ carry_nx) : 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
`ifdef ALU_SERIAL_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.zero   = zero_q;
`ifdef ALU_SERIAL_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
endmodule

// File: doc/alu_serial_seq.md
# alu_serial_seq

Bit-serial N-bit ALU sequencer. Latches two WIDTH-bit operands and an opcode on a start pulse, then processes one bit per clock, LSB first, through an internal 1-bit ALU slice with a registered carry. It presents the full result with carry and zero flags and a one-cycle done pulse. It is the multi-bit, clocked driver for the 1-bit ALU slice, for use where area matters more than latency.

## Interface

- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op  input  2  00 NOR, 01 XOR, 10 ADD (a+b), 11 SUB (a−b)
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result is valid
- result  output  WIDTH  operation result
- cout  output  1  final carry (ADD/SUB); 0 for NOR/XOR
- zero  output  1  result == 0
- ovf  output  1  signed overflow; present only with ALU_SERIAL_OVF_EN

## Operation

- States: IDLE, RUN, DONE.
- Reset (rst=1 at an edge) overrides all other inputs.
  - state←IDLE; busy, done, result, cout, zero, ovf all ←0.
  - Reset during RUN abandons the operation; no done pulse is produced.
- IDLE or DONE with start=1:
  - Latch a, b and op into shift registers A_sh, B_sh and op_r.
  - carry←1 if op=11, else 0.
  - bit counter←0.
  - →RUN.
- IDLE with start=0: hold.
- DONE with start=0: →IDLE.
- RUN, each edge: the slice evaluates a_i=A_sh[0], b_i=B_sh[0], carry.
  - NOR: s=~(a_i|b_i).
  - XOR: s=a_i^b_i.
  - ADD: s=a_i^b_i^carry; carry←majority(a_i,b_i,carry).
  - SUB: as ADD with b_i inverted.
  - carry updates only for ADD/SUB and holds 0 for NOR/XOR.
  - s shifts into the result shift register at the MSB; A_sh and B_sh shift right; counter increments.
- RUN, on the edge that processes bit WIDTH−1: →DONE.
  - cout←final carry (ADD/SUB) or 0.
  - zero←(final result==0).
- start is ignored while in RUN; operands and op are not re-sampled.
- result, cout, zero and ovf hold their last values from DONE until the next start is accepted. They are not cleared on accept; result updates only at the DONE transition.
- SUB: cout=1 means no borrow (a ≥ b unsigned).
- No internal wrap hazard: the counter is ⌈log2 WIDTH⌉ bits, compares to WIDTH−1, and resets on accept.

## Timing

- start accepted at edge k:
  - busy=1 after edge k through edge k+WIDTH−1.
  - Bit i is processed at edge k+1+i.
- After edge k+WIDTH:
  - state=DONE, busy=0, done=1 for exactly one cycle.
  - result, cout, zero and ovf are valid.
- Latency: WIDTH+1 cycles from start to done.
- Back-to-back: start=1 during the DONE cycle is accepted at edge k+WIDTH+1, giving throughput of one operation per WIDTH+1 cycles.
- Simultaneous rst and start: reset wins.

## Configuration

- ALU_SERIAL_OVF_EN defined:
  - Port ovf exists.
  - At the DONE transition, ovf←carry_into_MSB ^ carry_out_of_MSB for ADD/SUB, and 0 for NOR/XOR.
  - ovf resets to 0.
- ALU_SERIAL_OVF_EN undefined:
  - Port ovf and its logic are absent.
  - All other behaviour is identical.

## Test plan

All scenarios use WIDTH=8.

- ADD a=0x5A, b=0x3C, start at edge k -> done at k+8; result=0x96, cout=0, zero=0, ovf=1.
- SUB a=0x10, b=0x20 -> result=0xF0, cout=0, ovf=0; then SUB a=0x20, b=0x20 -> result=0x00, cout=1, zero=1.
- NOR a=0xF0, b=0x0C -> result=0x03, cout=0; XOR a=0xFF, b=0xFF -> result=0x00, zero=1, cout=0.
- ADD 0x01+0x01 started, then start pulsed at k+3 with a=0xFF, op=00 -> ignored; result=0x02 at k+8, a single done pulse.
- rst asserted at k+4 mid-ADD -> busy=0, result=0, no done pulse; a new ADD 0x80+0x80 -> result=0x00, cout=1, zero=1, ovf=1.
- start held high through the DONE cycle with XOR 0xAA^0x55 queued -> first done at k+8, second accepted at k+9, second done at k+17 with result=0xFF.
